oled_spi_tx: RTL and testbench

SPI byte transmitter that drives the SSD1306-class OLED panel's 4-wire serial interface (SCLK, MOSI, CS#, D/C#). It is the far end of the `spi_send` / `spi_data` / `dc` / `send_done` handshake used by the OLED command/data sequencers (init, clear, write-data), shared through a mux upstream. It serialises one byte per request, MSB first, in SPI mode 0, and pulses `send_done` when the byte is fully on the wire.

---
 rtl/oled_pkg.sv | 17 +
 rtl/oled_spi_tx_if.sv | 21 ++
 rtl/oled_spi_tick.sv | 37 +++
 rtl/oled_spi_tx.sv | 121 ++++++++++++
 tb/tb_oled_spi_tx.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/oled_pkg.sv
// Shared types and constants for the OLED SPI path.
// Used by the byte transmitter and its strobe generator.
package oled_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        HOLD,
        DONE
    } spi_tx_st_t;

    localparam logic OLED_DC_CMD  = 1'b0;
    localparam logic OLED_DC_DATA = 1'b1;

    localparam int unsigned OLED_SPI_CLK_DIV = 4;

endpackage

// File: rtl/oled_spi_tx_if.sv
// Byte request/complete handshake between the OLED sequencers
// and the SPI transmitter.
interface oled_spi_tx_if;

    logic       spi_send;
    logic [7:0] spi_data;
    logic       dc;
    logic       send_done;
    logic       busy;

    modport master (
        output spi_send, spi_data, dc,
        input  send_done, busy
    );

    modport slave (
        input  spi_send, spi_data, dc,
        output send_done, busy
    );

endinterface

// File: rtl/oled_spi_tick.sv
// Half-period strobe: one-cycle tick every CLK_DIV cycles,
// restarted by a synchronous clear.
module oled_spi_tick
    import oled_pkg::*;
#(
    parameter int unsigned CLK_DIV = OLED_SPI_CLK_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = $clog2(CLK_DIV) + 1;
    localparam logic [CW-1:0] TOP = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == TOP);

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/oled_spi_tx.sv
// SSD1306 4-wire SPI byte transmitter, mode 0, MSB first.
// MOSI is the top bit of the shift register so it stays registered.
module oled_spi_tx
    import oled_pkg::*;
#(
    parameter int unsigned CLK_DIV = OLED_SPI_CLK_DIV
) (
    input  logic          clk,
    input  logic          reset,
    oled_spi_tx_if.slave  bus,
    output logic          oled_sclk,
    output logic          oled_mosi,
    output logic          oled_cs_n,
    output logic          oled_dc
);

    spi_tx_st_t st_q, st_d;
    logic [7:0] sr_q, sr_d;
    logic [2:0] bit_q, bit_d;
    logic       sclk_q, sclk_d;
    logic       cs_n_q, cs_n_d;
    logic       dc_q, dc_d;
    logic       done_q, done_d;
    logic       busy_q, busy_d;
    logic       clr;
    logic       tick;

    oled_spi_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .tick  (tick)
    );

    always_comb begin
        st_d   = st_q;
        sr_d   = sr_q;
        bit_d  = bit_q;
        sclk_d = sclk_q;
        cs_n_d = cs_n_q;
        dc_d   = dc_q;
        done_d = 1'b0;
        busy_d = busy_q;
        clr    = 1'b0;
        unique case (st_q)
            IDLE: begin
                if (bus.spi_send) begin
                    st_d   = SHIFT;
                    sr_d   = bus.spi_data;
                    bit_d  = '0;
                    cs_n_d = 1'b0;
                    dc_d   = bus.dc;
                    busy_d = 1'b1;
                    clr    = 1'b1;
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        sclk_d = 1'b0;
                        // Data changes only on the falling edge
                        if (bit_q == 3'd7) begin
                            st_d = HOLD;
                        end else begin
                            sr_d  = {sr_q[6:0], 1'b0};
                            bit_d = bit_q + 3'd1;
                        end
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    st_d   = DONE;
                    cs_n_d = 1'b1;
                    done_d = 1'b1;
                end
            end
            DONE: begin
                st_d   = IDLE;
                busy_d = 1'b0;
            end
            default: begin
                st_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q   <= IDLE;
            sr_q   <= '0;
            bit_q  <= '0;
            sclk_q <= 1'b0;
            cs_n_q <= 1'b1;
            dc_q   <= 1'b0;
            done_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            sr_q   <= sr_d;
            bit_q  <= bit_d;
            sclk_q <= sclk_d;
            cs_n_q <= cs_n_d;
            dc_q   <= dc_d;
            done_q <= done_d;
            busy_q <= busy_d;
        end
    end

    assign oled_sclk     = sclk_q;
    assign oled_mosi     = sr_q[7];
    assign oled_cs_n     = cs_n_q;
    assign oled_dc       = dc_q;
    assign bus.send_done = done_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_oled_spi_tx.sv
// Directed bench for oled_spi_tx at CLK_DIV=2 (dut a)
// and CLK_DIV=1 (dut b).
module tb_oled_spi_tx;
    import oled_pkg::*;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    logic a_sclk, a_mosi, a_cs_n, a_dc;
    logic b_sclk, b_mosi, b_cs_n, b_dc;

    oled_spi_tx_if a_if ();
    oled_spi_tx_if b_if ();

    oled_spi_tx #(.CLK_DIV(2)) dut_a (
        .clk       (clk),
        .reset     (reset),
        .bus       (a_if.slave),
        .oled_sclk (a_sclk),
        .oled_mosi (a_mosi),
        .oled_cs_n (a_cs_n),
        .oled_dc   (a_dc)
    );

    oled_spi_tx #(.CLK_DIV(1)) dut_b (
        .clk       (clk),
        .reset     (reset),
        .bus       (b_if.slave),
        .oled_sclk (b_sclk),
        .oled_mosi (b_mosi),
        .oled_cs_n (b_cs_n),
        .oled_dc   (b_dc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called just after the accept edge; samples cycles 1..17h+1
    // plus one idle cycle.
    task automatic watch(input bit sel, input int h,
                         input logic [7:0] ed, input logic edc,
                         input int drop_at, input string tag);
        logic [7:0] got = '0;
        int nr = 0, r0 = -1, lf = -1, dn = -1, ndone = 0;
        int csbad = 0, bbad = 0, gapbad = 0, lastr = 0;
        logic ps = 1'b0, dcp = 1'b0;
        logic s, m, cs, bz, dv;
        for (int n = 1; n <= 17 * h + 1; n++) begin
            @(negedge clk);
            s  = sel ? b_sclk : a_sclk;
            m  = sel ? b_mosi : a_mosi;
            cs = sel ? b_cs_n : a_cs_n;
            bz = sel ? b_if.busy : a_if.busy;
            dv = sel ? b_if.send_done : a_if.send_done;
            if (n == 1) dcp = sel ? b_dc : a_dc;
            if (s && !ps) begin
                got = {got[6:0], m};
                if (nr == 0) r0 = n - 1;
                else if (n - 1 - lastr != 2 * h) gapbad++;
                lastr = n - 1;
                nr++;
            end
            if (!s && ps) lf = n - 1;
            if (dv) begin
                ndone++;
                if (dn < 0) dn = n;
            end
            if (cs != (n == 17 * h + 1)) csbad++;
            if (!bz) bbad++;
            ps = s;
            if (n == drop_at) begin
                if (sel) begin
                    b_if.spi_send = 1'b0;
                    b_if.spi_data = 8'h00;
                end else begin
                    a_if.spi_send = 1'b0;
                    a_if.spi_data = 8'h00;
                end
            end
        end
        chk({tag, ".data"}, 32'(got), 32'(ed));
        chk({tag, ".dc"}, 32'(dcp), 32'(edc));
        chk({tag, ".nrise"}, nr, 8);
        chk({tag, ".rise0"}, r0, h);
        chk({tag, ".gap"}, gapbad, 0);
        chk({tag, ".lastfall"}, lf, 16 * h);
        chk({tag, ".done_at"}, dn, 17 * h + 1);
        chk({tag, ".ndone"}, ndone, 1);
        chk({tag, ".cs"}, csbad, 0);
        chk({tag, ".busy"}, bbad, 0);
        @(negedge clk);
        s  = sel ? b_sclk : a_sclk;
        m  = sel ? b_mosi : a_mosi;
        bz = sel ? b_if.busy : a_if.busy;
        dv = sel ? b_if.send_done : a_if.send_done;
        chk({tag, ".post"}, {28'd0, s, bz, dv, m}, {28'd0, 3'b000, ed[0]});
    endtask

    logic [7:0] seq_d [4] = '{8'hB2, 8'h10, 8'h05, 8'hFF};
    logic       seq_c [4] = '{OLED_DC_CMD, OLED_DC_CMD, OLED_DC_CMD,
                              OLED_DC_DATA};

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ba, bb, extra;
        time t_prev, t_now;
        total = 0;
        bad = 0;
        reset = 1'b1;
        a_if.spi_send = 1'b0;
        a_if.spi_data = 8'h00;
        a_if.dc = 1'b0;
        b_if.spi_send = 1'b0;
        b_if.spi_data = 8'h00;
        b_if.dc = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        ba = 0;
        bb = 0;
        repeat (20) begin
            @(negedge clk);
            if ({a_sclk, a_mosi, a_cs_n, a_dc, a_if.send_done, a_if.busy}
                !== 6'b001000) ba++;
            if ({b_sclk, b_mosi, b_cs_n, b_dc, b_if.send_done, b_if.busy}
                !== 6'b001000) bb++;
        end
        chk("idle.a", ba, 0);
        chk("idle.b", bb, 0);

        a_if.spi_send = 1'b1;
        a_if.spi_data = 8'hB3;
        a_if.dc = OLED_DC_CMD;
        @(posedge clk);
        watch(1'b0, 2, 8'hB3, 1'b0, 1, "b3");

        a_if.spi_send = 1'b1;
        a_if.spi_data = seq_d[0];
        a_if.dc = seq_c[0];
        t_prev = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            t_now = $time;
            if (i > 0) chk("seq.period", 32'((t_now - t_prev) / 10), 36);
            t_prev = t_now;
            watch(1'b0, 2, seq_d[i], seq_c[i], 0, "seq");
            if (i < 3) begin
                a_if.spi_data = seq_d[i+1];
                a_if.dc = seq_c[i+1];
            end else begin
                a_if.spi_send = 1'b0;
            end
        end
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (!a_cs_n || a_if.busy || a_if.send_done) extra++;
        end
        chk("seq.extra", extra, 0);

        a_if.spi_send = 1'b1;
        a_if.spi_data = 8'hA5;
        a_if.dc = OLED_DC_DATA;
        @(posedge clk);
        watch(1'b0, 2, 8'hA5, 1'b1, 5, "drop");

        a_if.spi_send = 1'b1;
        a_if.spi_data = 8'hC3;
        a_if.dc = OLED_DC_CMD;
        @(posedge clk);
        repeat (10) @(negedge clk);
        chk("rst.pre", {31'd0, a_cs_n}, 0);
        reset = 1'b1;
        a_if.spi_send = 1'b0;
        #1;
        chk("rst.async", {29'd0, a_cs_n, a_sclk, a_if.busy}, 3'b100);
        extra = 0;
        repeat (4) begin
            @(negedge clk);
            if (a_if.send_done) extra++;
        end
        reset = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (a_if.send_done || !a_cs_n) extra++;
        end
        chk("rst.nodone", extra, 0);
        chk("rst.idle", {28'd0, a_sclk, a_mosi, a_cs_n, a_dc}, 4'b0010);
        a_if.spi_send = 1'b1;
        a_if.spi_data = 8'h5A;
        a_if.dc = OLED_DC_DATA;
        @(posedge clk);
        watch(1'b0, 2, 8'h5A, 1'b1, 1, "rst.new");

        b_if.spi_send = 1'b1;
        b_if.spi_data = 8'h80;
        b_if.dc = OLED_DC_CMD;
        @(posedge clk);
        watch(1'b1, 1, 8'h80, 1'b0, 1, "div1");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
